// File: rtl/id_ex_pipe_reg.sv
// rtl/id_ex_pipe_reg.sv - decode-to-execute pipeline register with skid buffer, flush and stall/flush counters
module id_ex_pipe_reg #(
    parameter int M  = 32,
    parameter int N  = 5,
    parameter int C  = 8,
    parameter int CW = 16
) (
    input  logic          CLK,
    input  logic          CLR,
    input  logic          FLUSH,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [M-1:0]  rd1,
    input  logic [M-1:0]  rd2,
    input  logic [M-1:0]  SimmD,
    input  logic [M-1:0]  pcd,
    input  logic [N-1:0]  rsd,
    input  logic [N-1:0]  rtd,
    input  logic [N-1:0]  rdd,
    input  logic [N-1:0]  shd,
    input  logic [C-1:0]  ctrld,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [M-1:0]  re1,
    output logic [M-1:0]  re2,
    output logic [M-1:0]  SimmE,
    output logic [M-1:0]  pce,
    output logic [N-1:0]  rse,
    output logic [N-1:0]  rte,
    output logic [N-1:0]  rde,
    output logic [N-1:0]  she,
    output logic [C-1:0]  ctrle,
    output logic [CW-1:0] stall_cnt,
    output logic [CW-1:0] flush_cnt
);
    localparam int P = 4*M + 4*N + C;
    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [CW-1:0] ONE  = {{(CW-1){1'b0}}, 1'b1};

    logic          r_main_valid;
    logic          r_skid_valid;
    logic [P-1:0]  r_main;
    logic [P-1:0]  r_skid;
    logic [CW-1:0] r_stall;
    logic [CW-1:0] r_flush;

    logic [P-1:0]  w_in;
    logic          w_acc;
    logic          w_drn;
    logic          w_stall;

    assign w_in    = {rd1, rd2, SimmD, pcd, rsd, rtd, rdd, shd, ctrld};
    // in_ready is the inverted skid flag, so there is no path from out_ready
    assign w_acc   = in_valid & ~r_skid_valid;
    assign w_drn   = r_main_valid & out_ready;
    assign w_stall = r_main_valid & ~out_ready;

    always_ff @(posedge CLK) begin
        if (CLR) begin
            r_main_valid <= 1'b0;
            r_skid_valid <= 1'b0;
            r_main       <= '0;
            r_skid       <= '0;
            r_stall      <= '0;
            r_flush      <= '0;
        end else begin
            if (w_stall && r_stall != CMAX)
                r_stall <= r_stall + ONE;

            if (FLUSH) begin
                r_main_valid <= 1'b0;
                r_skid_valid <= 1'b0;
                r_main       <= '0;
                r_skid       <= '0;
                if ((r_main_valid | r_skid_valid) && r_flush != CMAX)
                    r_flush <= r_flush + ONE;
            end else if (!r_main_valid || w_drn) begin
                if (r_skid_valid) begin
                    r_main       <= r_skid;
                    r_main_valid <= 1'b1;
                    r_skid       <= '0;
                    r_skid_valid <= 1'b0;
                end else if (w_acc) begin
                    r_main       <= w_in;
                    r_main_valid <= 1'b1;
                end else begin
                    // bubble: zeroed payload keeps rde/ctrle harmless downstream
                    r_main       <= '0;
                    r_main_valid <= 1'b0;
                end
            end else if (w_acc) begin
                r_skid       <= w_in;
                r_skid_valid <= 1'b1;
            end
        end
    end

    assign in_ready  = ~r_skid_valid;
    assign out_valid = r_main_valid;
    assign {re1, re2, SimmE, pce, rse, rte, rde, she, ctrle} = r_main;
    assign stall_cnt = r_stall;
    assign flush_cnt = r_flush;

endmodule
